// File: rtl/des_key_sched_seq.sv
// Iterative DES key schedule: PC-1 once per request, then one C/D rotation per
// accepted subkey. Encrypt order is K1..K16 and decrypt order is K16..K1.
module des_key_sched_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] init_key,
  input  logic        encrypt_decrypt,
  output logic        busy,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        last
);

  localparam int KEY_W = 64;
  localparam int CD_W  = 56;
  localparam int RK_W  = 48;

  // Table entries use DES bit numbering, where bit 1 is the MSB.
  localparam logic [6:0] PC1_TAB [CD_W] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2_TAB [RK_W] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < CD_W; i++) begin
      r[CD_W - 1 - i] = k[KEY_W - int'(PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = 48'd0;
    for (int i = 0; i < RK_W; i++) begin
      r[RK_W - 1 - i] = cd[CD_W - int'(PC2_TAB[i])];
    end
    return r;
  endfunction

  // 0-based round index j; rounds 1, 2, 9 and 16 shift by one, all others shift by two.
  function automatic logic shift_two(input logic [3:0] j);
    logic r;
    case (j)
      4'd0, 4'd1, 4'd8, 4'd15: r = 1'b0;
      default:                 r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] h, input logic two);
    logic [27:0] r;
    if (two) begin
      r = {h[25:0], h[27:26]};
    end else begin
      r = {h[26:0], h[27]};
    end
    return r;
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] h, input logic two);
    logic [27:0] r;
    if (two) begin
      r = {h[1:0], h[27:2]};
    end else begin
      r = {h[0], h[27:1]};
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic [47:0] key_q, key_d;
  logic [3:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic [55:0] cd0_s;
  logic        two_s;
  logic        load_s;

  // Next-state, C/D rotation and next subkey selection.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    key_d   = key_q;
    idx_d   = idx_q;
    last_d  = last_q;
    two_s   = 1'b0;
    load_s  = 1'b0;
    cd0_s   = pc1(init_key);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EMIT;
          dec_d   = encrypt_decrypt;
          cnt_d   = 4'd0;
          last_d  = 1'b0;
          load_s  = 1'b1;
          // Decrypt starts at C0/D0, which is the same state as C16/D16.
          if (encrypt_decrypt) begin
            c_d   = cd0_s[55:28];
            d_d   = cd0_s[27:0];
            idx_d = 4'd15;
          end else begin
            c_d   = rotl(cd0_s[55:28], 1'b0);
            d_d   = rotl(cd0_s[27:0], 1'b0);
            idx_d = 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (key_ready) begin
          if (cnt_q == 4'd15) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            last_d = (cnt_q == 4'd14);
            load_s = 1'b1;
            if (dec_q) begin
              // Undo the shift of the round just emitted.
              two_s = shift_two(4'd15 - cnt_q);
              c_d   = rotr(c_q, two_s);
              d_d   = rotr(d_q, two_s);
              idx_d = 4'd14 - cnt_q;
            end else begin
              two_s = shift_two(cnt_q + 4'd1);
              c_d   = rotl(c_q, two_s);
              d_d   = rotl(d_q, two_s);
              idx_d = cnt_q + 4'd1;
            end
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load_s) begin
      key_d = pc2({c_d, d_d});
    end else begin
      key_d = key_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      c_q     <= 28'd0;
      d_q     <= 28'd0;
      cnt_q   <= 4'd0;
      dec_q   <= 1'b0;
      key_q   <= 48'd0;
      idx_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign busy      = (state_q == S_EMIT);
  assign key_valid = (state_q == S_EMIT);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign last      = last_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Self-checking bench for des_key_sched_seq: known-answer table, random keys
// against a whole-schedule reference model, backpressure and reset sequences.
module tb_des_key_sched_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] init_key;
  logic        encrypt_decrypt;
  logic        busy;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] round_key;
  logic [3:0]  round_idx;
  logic        last;

  int errors = 0;
  int checks = 0;

  des_key_sched_seq dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .init_key        (init_key),
    .encrypt_decrypt (encrypt_decrypt),
    .busy            (busy),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .round_key       (round_key),
    .round_idx       (round_idx),
    .last            (last)
  );

  always #5 clk = ~clk;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [47:0] exp_keys [16];
  logic [3:0]  exp_idx  [16];
  logic [47:0] got_keys [16];
  logic [3:0]  got_idx  [16];
  logic [47:0] enc_ref  [16];

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          mode;     // 0 ready, 1 random ready, 2 stall on 5th, 3 stray start
    int          ref_cmp;  // 0 none, 1 equal to enc_ref, 2 reverse of enc_ref
    logic [47:0] k_first;
    logic [3:0]  i_first;
    logic [47:0] k_last;
    logic [3:0]  i_last;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: C_r/D_r is C0/D0 rotated left by the cumulative shift total.
  task automatic gen_model(input logic [63:0] key, input logic dec);
    logic [55:0] cd0;
    logic [47:0] enc [16];
    int tot;
    int p;
    int half;
    int src;
    tot = 0;
    for (int i = 0; i < 56; i++) cd0[55 - i] = key[64 - PC1_T[i]];
    for (int r = 1; r <= 16; r++) begin
      tot += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      for (int j = 0; j < 48; j++) begin
        p    = PC2_T[j];
        half = (p > 28) ? 28 : 0;
        src  = half + ((p - 1 - half + tot) % 28) + 1;
        enc[r - 1][47 - j] = cd0[56 - src];
      end
    end
    for (int n = 0; n < 16; n++) begin
      exp_keys[n] = dec ? enc[15 - n] : enc[n];
      exp_idx[n]  = dec ? 4'(15 - n) : 4'(n);
    end
  endtask

  task automatic run_sched(input logic [63:0] key, input logic dec, input int mode,
                           input int abort_at);
    int  n;
    int  cyc;
    int  stall;
    bit  pulsed;
    bit  rdy;
    gen_model(key, dec);
    n = 0; cyc = 0; stall = 0; pulsed = 1'b0;
    start = 1'b1; init_key = key; encrypt_decrypt = dec; key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    init_key = {$urandom, $urandom};
    encrypt_decrypt = ~dec;
    chk("busy_after_start", busy, 1'b1);
    while (n < 16 && n != abort_at && cyc < 300) begin
      start = 1'b0;
      if (key_valid !== 1'b1) begin
        chk("key_valid_held", key_valid, 1'b1);
        break;
      end
      chk("round_key", round_key, exp_keys[n]);
      chk("round_idx", round_idx, exp_idx[n]);
      chk("last", last, (n == 15));
      got_keys[n] = round_key;
      got_idx[n]  = round_idx;
      rdy = 1'b1;
      if (mode == 1) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else if (mode == 2 && n == 4 && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end else if (mode == 3 && n == 3 && !pulsed) begin
        start = 1'b1;
        init_key = 64'd0;
        encrypt_decrypt = ~dec;
        pulsed = 1'b1;
      end
      key_ready = rdy;
      if (rdy) n++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (n != abort_at) begin
      chk("handshakes", n, 16);
      if (mode == 0 || mode == 3) chk("cycles", cyc, 16);
      if (mode == 2) chk("stall_cycles", cyc, 19);
      chk("busy_done", busy, 1'b0);
      chk("valid_done", key_valid, 1'b0);
      chk("last_done", last, 1'b0);
      chk("key_retained", round_key, exp_keys[15]);
      chk("idx_retained", round_idx, exp_idx[15]);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_valid"}, key_valid, 1'b0);
    chk({name, "_key"}, round_key, 48'd0);
    chk({name, "_idx"}, round_idx, 4'd0);
    chk({name, "_last"}, last, 1'b0);
  endtask

  initial begin
    vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 0, 0, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};
    vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 0, 2, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 4'd0};
    vecs[2] = '{64'h133457799BBCDFF1, 1'b0, 2, 1, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};
    vecs[3] = '{64'h133457799BBCDFF1, 1'b0, 3, 1, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};
    vecs[4] = '{64'h123556789ABDDEF0, 1'b0, 0, 1, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};
    vecs[5] = '{64'h123556789ABDDEF0, 1'b1, 1, 2, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 4'd0};

    rst = 1'b0; start = 1'b0; key_ready = 1'b0;
    init_key = 64'd0; encrypt_decrypt = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("idle_after_reset");

    for (int i = 0; i < 6; i++) begin
      run_sched(vecs[i].key, vecs[i].dec, vecs[i].mode, 16);
      chk("first_key", got_keys[0], vecs[i].k_first);
      chk("first_idx", got_idx[0], vecs[i].i_first);
      chk("last_key", got_keys[15], vecs[i].k_last);
      chk("last_idx", got_idx[15], vecs[i].i_last);
      if (i == 0) begin
        enc_ref = got_keys;
        chk("k2", got_keys[1], 48'h79AED9DBC9E5);
      end
      for (int k = 0; k < 16; k++) begin
        if (vecs[i].ref_cmp == 1) chk("same_as_encrypt", got_keys[k], enc_ref[k]);
        if (vecs[i].ref_cmp == 2) chk("reverse_of_encrypt", got_keys[k], enc_ref[15 - k]);
      end
    end

    for (int i = 0; i < 8; i++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1, 16);
    end

    run_sched(64'h133457799BBCDFF1, 1'b0, 0, 7);
    #2 rst = 1'b1;
    #1 chk_zero("reset_mid_schedule");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle_after_mid_reset");
    run_sched(64'h133457799BBCDFF1, 1'b0, 0, 16);
    chk("restart_k1", got_keys[0], 48'h1B02EFFC7072);
    chk("restart_idx", got_idx[0], 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_key_sched_seq.md
# des_key_sched_seq

Iterative DES key scheduler that streams the 16 round subkeys one per handshake instead of producing all 768 bits at once. It performs PC-1 once at start. It then walks the C/D halves with left rotations (encrypt order, K1→K16) or right rotations (decrypt order, K16→K1), emitting PC-2 of the current state. It feeds a round-iterative cipher datapath through a valid/ready interface, saving the 16-stage combinational schedule and the output mux.

## Interface
- No parameters (DES widths fixed: 64-bit key, 56-bit C/D, 48-bit subkey).
- One clock; reset is asynchronous and active-high.
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — request a new schedule; accepted only when `busy`=0.
- `init_key` in 64 — DES key; bit 63 = DES bit 1; parity bits (DES bits 8,16,…,64) ignored.
- `encrypt_decrypt` in 1 — 0 = encrypt order (K1..K16), 1 = decrypt order (K16..K1).
- `busy` out 1 — schedule in progress.
- `key_valid` out 1 — `round_key` holds a valid subkey.
- `key_ready` in 1 — consumer accepts subkey this cycle.
- `round_key` out 48 — current subkey; bit 47 = PC-2 output bit 1.
- `round_idx` out 4 — DES round (0-based) the subkey belongs to.
- `last` out 1 — current subkey is the 16th emitted.

## Operation
- FSM states: IDLE, EMIT.
- IDLE: `start`=1 → sample `init_key`, `encrypt_decrypt`. Load C0/D0 = PC-1(`init_key`), C = 28 MSBs. Load first subkey into output regs. Then go to EMIT.
- Shift schedule s_r (r = 1..16): 1 for r ∈ {1,2,9,16}, else 2; total 28 per half.
- Encrypt: state register holds C_r/D_r of the emitted key.
  - First key: C1 = LROT(C0,1), K1 = PC-2(C1‖D1).
  - Each handshake: C_{r+1} = LROT(C_r, s_{r+1}); emit PC-2.
- Decrypt: first state = C0/D0 (≡ C16/D16), K16 = PC-2(C0‖D0).
  - Each handshake with current round r: C_{r-1} = RROT(C_r, s_r); emit PC-2.
- Emit counter `cnt` 0..15 counts emitted keys.
  - `round_idx` = `cnt` (encrypt) or 15−`cnt` (decrypt).
  - `last` = (`cnt`==15).
- Handshake = `key_valid` & `key_ready`.
  - Not last → advance state, `cnt`+1, new subkey registered.
  - Last → `key_valid`←0, `last`←0, return to IDLE.
- `start` while `busy`=1 is ignored. Sampled inputs are not re-read mid-schedule.
- `round_key`, `round_idx`, `last` are registered and stable while `key_valid`=1 and `key_ready`=0.
- After completion, `round_key` and `round_idx` retain the final values; `key_valid`=0.

## Timing
- Reset (async assert, any state): `busy`=0, `key_valid`=0, `round_key`=0, `round_idx`=0, `last`=0, `cnt`=0, C/D=0, FSM=IDLE. Reset mid-schedule discards the schedule.
- `start` accepted at edge t → `busy`=1 and `key_valid`=1 with first subkey from t+1.
- `key_ready` held 1 → one subkey per cycle, 16 consecutive valid cycles t+1..t+16.
- `busy`=0 from t+17. A new `start` is accepted in any cycle with `busy`=0, including t+17.
- Backpressure stalls without loss or duplication. Throughput is one key per handshake cycle.
- `busy` = (FSM==EMIT); it equals `key_valid` in this design.
- No combinational path from `key_ready` or `start` to any output.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately. Hold `start`=0 after release → outputs stay 0.
- Encrypt, `init_key`=0x133457799BBCDFF1, `key_ready`=1:
  - Keys on cycles t+1..t+16.
  - K1=0x1B02EFFC7072 (`round_idx` 0).
  - K2=0x79AED9DBC9E5 (`round_idx` 1).
  - Final K16=0xCB3D8B0E17F5 with `round_idx`=15, `last`=1.
  - `busy`=0 at t+17.
- Decrypt, same key:
  - First key 0xCB3D8B0E17F5 (`round_idx` 15), second 0x79…? no — second equals the encrypt-mode K15.
  - Final 0x1B02EFFC7072 (`round_idx` 0, `last`=1).
  - Each subkey equals the encrypt run in reverse order.
- Backpressure: drop `key_ready` for 3 cycles while 5th key valid → `round_key`/`round_idx` unchanged, `key_valid` held. Resume → sequence continues with 6th key; 16 distinct keys total.
- Ignored start and parity: pulse `start` with key 0 during an active schedule → sequence unaffected. Then run 0x123556789ABDDEF0 (parity bits flipped) → identical subkeys to 0x133457799BBCDFF1.
- Reset mid-operation: assert `rst` after 7 handshakes → idle, outputs 0. New encrypt `start` → first key K1=0x1B02EFFC7072, `round_idx`=0.
